// File: rtl/bus_control_fsm_pkg.sv
// Shared constants for the single-bus control sequencer: opcodes and FSM states.
package bus_control_fsm_pkg;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

endpackage

// File: rtl/bus_control_fsm_dec2to4.sv
// 2-to-4 one-hot decoder with enable; output is all zeros when disabled.
module dec2to4 (
  input  logic [1:0] idx,
  input  logic       en,
  output logic [3:0] y
);

  always_comb begin
    y = 4'b0000;
    if (en) y = 4'b0001 << idx;
  end

endmodule

// File: rtl/bus_control_fsm.sv
// Control sequencer for the 4-bit single-bus datapath: latches one instruction
// per start and steps the bus source/sink controls until the Done pulse.
module bus_control_fsm
  import bus_control_fsm_pkg::*;
(
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       w,
  input  logic [5:0] func,
  output logic       Extern,
  output logic       Gout,
  output logic [3:0] Rout,
  output logic [3:0] Rin,
  output logic       Ain,
  output logic       Gin,
  output logic       AddSub,
  output logic       Done,
  output logic [1:0] state_dbg
);

  // Start handshake: w acts as valid and the controller is ready only in T0;
  // an instruction is taken on any rising edge where state==T0 and w==1.
  state_t     state, state_nxt;
  logic [5:0] fr;
  logic [1:0] op, rx, ry;
  logic [1:0] rout_idx;
  logic       rin_en, rout_en;

  assign op = fr[5:4];
  assign rx = fr[3:2];
  assign ry = fr[1:0];
  assign state_dbg = state;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= T0;
      fr    <= 6'd0;
    end else begin
      state <= state_nxt;
      if (state == T0 && w) fr <= func;
    end
  end

  always_comb begin
    state_nxt = T0;
    case (state)
      T0: state_nxt = w ? T1 : T0;
      T1: state_nxt = (op == OP_ADD || op == OP_SUB) ? T2 : T0;
      T2: state_nxt = T3;
      T3: state_nxt = T0;
      default: state_nxt = T0;
    endcase
  end

  // Outputs depend only on state and the latched FR, so a changing func/w
  // mid-instruction can never disturb the bus.
  always_comb begin
    Extern   = 1'b0;
    Gout     = 1'b0;
    Ain      = 1'b0;
    Gin      = 1'b0;
    AddSub   = 1'b0;
    Done     = 1'b0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_idx = ry;
    case (state)
      T1: begin
        case (op)
          OP_LOAD: begin
            Extern = 1'b1;
            rin_en = 1'b1;
            Done   = 1'b1;
          end
          OP_MOV: begin
            rout_en = 1'b1;
            rin_en  = 1'b1;
            Done    = 1'b1;
          end
          default: begin
            rout_idx = rx;
            rout_en  = 1'b1;
            Ain      = 1'b1;
          end
        endcase
      end
      T2: begin
        rout_en = 1'b1;
        Gin     = 1'b1;
        AddSub  = op[0];
      end
      T3: begin
        Gout   = 1'b1;
        rin_en = 1'b1;
        Done   = 1'b1;
      end
      default: ;
    endcase
  end

  dec2to4 u_rin_dec (
    .idx (rx),
    .en  (rin_en),
    .y   (Rin)
  );

  dec2to4 u_rout_dec (
    .idx (rout_idx),
    .en  (rout_en),
    .y   (Rout)
  );

endmodule

// File: tb/tb_bus_control_fsm.sv
// Directed bench for bus_control_fsm: hand-computed output vectors per step,
// plus a per-cycle bus-source exclusivity check.
module tb_bus_control_fsm;

  logic       Clock;
  logic       Resetn;
  logic       w;
  logic [5:0] func;
  logic       Extern, Gout, Ain, Gin, AddSub, Done;
  logic [3:0] Rout, Rin;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  bus_control_fsm dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .w         (w),
    .func      (func),
    .Extern    (Extern),
    .Gout      (Gout),
    .Rout      (Rout),
    .Rin       (Rin),
    .Ain       (Ain),
    .Gin       (Gin),
    .AddSub    (AddSub),
    .Done      (Done),
    .state_dbg (state_dbg)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Packed view: {Extern, Gout, Rout[3:0], Rin[3:0], Ain, Gin, AddSub, Done}
  function automatic logic [13:0] mk(input logic ext, input logic go, input logic [3:0] ro,
                                     input logic [3:0] ri, input logic ai, input logic gi,
                                     input logic as, input logic dn);
    return {ext, go, ro, ri, ai, gi, as, dn};
  endfunction

  localparam logic [13:0] ZERO = 14'd0;

  task automatic chk(input string tag, input logic [13:0] exp);
    logic [13:0] obs;
    obs = {Extern, Gout, Rout, Rin, Ain, Gin, AddSub, Done};
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [1:0] exp);
    n_checks++;
    assert (state_dbg === exp) else begin
      n_errors++;
      $error("FAIL %s: observed state %0d expected %0d", tag, state_dbg, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  always @(negedge Clock) begin
    if (Resetn === 1'b1) begin
      n_checks++;
      assert ($countones({Extern, Gout, Rout}) <= 1) else begin
        n_errors++;
        $error("FAIL bus_excl: observed Extern=%b Gout=%b Rout=%b expected at most one source",
               Extern, Gout, Rout);
      end
    end
  end

  initial begin
    Resetn = 1'b1;
    w      = 1'b0;
    func   = 6'd0;

    // Asynchronous reset mid-cycle
    #3 Resetn = 1'b0;
    #1 chk("reset_async", ZERO);
    chk_state("reset_state", 2'd0);
    step();
    step();
    #2 Resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("idle_%0d", i), ZERO);
    end

    // Load R2 <- Data
    w = 1'b1; func = 6'b00_10_01;
    step();
    chk("load_t1", mk(1, 0, 4'b0000, 4'b0100, 0, 0, 0, 1));
    chk_state("load_state", 2'd1);
    w = 1'b0;
    step();
    chk("load_after", ZERO);

    // Mov R1 <- R2
    w = 1'b1; func = 6'b01_01_10;
    step();
    chk("mov_t1", mk(0, 0, 4'b0100, 4'b0010, 0, 0, 0, 1));
    w = 1'b0;
    step();
    chk("mov_after", ZERO);

    // Sub R0 <- R0 - R3
    w = 1'b1; func = 6'b11_00_11;
    step();
    chk("sub_t1", mk(0, 0, 4'b0001, 4'b0000, 1, 0, 0, 0));
    w = 1'b0;
    step();
    chk("sub_t2", mk(0, 0, 4'b1000, 4'b0000, 0, 1, 1, 0));
    chk_state("sub_t2_state", 2'd2);
    step();
    chk("sub_t3", mk(0, 1, 4'b0000, 4'b0001, 0, 0, 0, 1));
    step();
    chk("sub_after", ZERO);

    // Add R0 <- R0 + R3
    w = 1'b1; func = 6'b10_00_11;
    step();
    chk("add_t1", mk(0, 0, 4'b0001, 4'b0000, 1, 0, 0, 0));
    w = 1'b0;
    step();
    chk("add_t2", mk(0, 0, 4'b1000, 4'b0000, 0, 1, 0, 0));
    step();
    chk("add_t3", mk(0, 1, 4'b0000, 4'b0001, 0, 0, 0, 1));
    step();
    chk("add_after", ZERO);

    // Add with Rx == Ry (R2 <- R2 + R2)
    w = 1'b1; func = 6'b10_10_10;
    step();
    chk("addrr_t1", mk(0, 0, 4'b0100, 4'b0000, 1, 0, 0, 0));
    w = 1'b0;
    step();
    chk("addrr_t2", mk(0, 0, 4'b0100, 4'b0000, 0, 1, 0, 0));
    step();
    chk("addrr_t3", mk(0, 1, 4'b0000, 4'b0100, 0, 0, 0, 1));
    step();
    chk("addrr_after", ZERO);

    // Held start: load R3 back-to-back; func disturbed during every T1
    w = 1'b1; func = 6'b00_11_00;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i % 2 == 1) begin
        chk($sformatf("held_t1_%0d", i), mk(1, 0, 4'b0000, 4'b1000, 0, 0, 0, 1));
        func = 6'b01_00_01;
      end else begin
        chk($sformatf("held_t0_%0d", i), ZERO);
        func = 6'b00_11_00;
      end
    end
    w = 1'b0;
    step();
    chk("held_end", ZERO);

    // Reset during T2 of an add
    w = 1'b1; func = 6'b10_01_10;
    step();
    chk("abort_t1", mk(0, 0, 4'b0010, 4'b0000, 1, 0, 0, 0));
    w = 1'b0;
    step();
    chk("abort_t2", mk(0, 0, 4'b0100, 4'b0000, 0, 1, 0, 0));
    #2 Resetn = 1'b0;
    #1 chk("abort_reset", ZERO);
    chk_state("abort_state", 2'd0);
    #2 Resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("abort_idle_%0d", i), ZERO);
    end

    // Next load completes normally
    w = 1'b1; func = 6'b00_01_00;
    step();
    chk("post_load_t1", mk(1, 0, 4'b0000, 4'b0010, 0, 0, 0, 1));
    w = 1'b0;
    step();
    chk("post_load_after", ZERO);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
